// File: rtl/alu_result_buffer_pkg.sv
// Shared definitions for the ALU result buffer: flag bit positions and field widths.
// Flags are packed {carry, zero, negative, overflow, underflow}.
package alu_result_buffer_pkg;

  localparam int FLAG_W = 5;
  localparam int SEL_W  = 4;

  localparam int FLAG_CARRY     = 4;
  localparam int FLAG_ZERO      = 3;
  localparam int FLAG_NEGATIVE  = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  localparam logic [7:0] EXC_MAX = 8'hFF;

  // An entry counts as an exception when either overflow or underflow is set.
  function automatic logic is_exception(input logic [FLAG_W-1:0] flags);
    return flags[FLAG_OVERFLOW] | flags[FLAG_UNDERFLOW];
  endfunction

endpackage

// File: rtl/alu_result_fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one asynchronous read port.
module alu_result_fifo_mem #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the occupancy counter,
  // so stale contents are never observed while the buffer reports empty.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// In-order FIFO of ALU results {result, sel, flags} with sticky flag accumulation
// and a saturating count of overflow/underflow results.
module alu_result_buffer
  import alu_result_buffer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [FLAG_W-1:0]        in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [SEL_W-1:0]         out_sel,
  output logic [FLAG_W-1:0]        out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic [FLAG_W-1:0]        sticky_flags,
  input  logic                     sticky_clr,
  output logic [7:0]               exc_count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_W   = AW + 1;
  localparam int ENTRY_W = DATA_W + SEL_W + FLAG_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [FLAG_W-1:0]  r_sticky;
  logic [7:0]         r_exc;

  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [FLAG_W-1:0]  w_sticky_nxt;
  logic [7:0]         w_exc_base;
  logic [7:0]         w_exc_nxt;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_rd_entry;

  // Handshakes depend only on registered occupancy, never on the partner's signal.
  assign in_ready  = (r_count < FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // A clear and a same-cycle push leave only the newly pushed contribution.
  always_comb begin
    w_sticky_nxt = (sticky_clr ? '0 : r_sticky) | (w_push ? in_flags : '0);
    w_exc_base   = sticky_clr ? 8'd0 : r_exc;
    w_exc_nxt    = w_exc_base;
    if (w_push && is_exception(in_flags) && (w_exc_base != EXC_MAX))
      w_exc_nxt = w_exc_base + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_sticky <= '0;
      r_exc    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= w_count_nxt;
      r_sticky <= w_sticky_nxt;
      r_exc    <= w_exc_nxt;
    end
  end

  assign w_wr_entry = {in_result, in_sel, in_flags};

  alu_result_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push & ~rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  assign {out_result, out_sel, out_flags} = w_rd_entry;
  assign count        = r_count;
  assign sticky_flags = r_sticky;
  assign exc_count    = r_exc;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed self-checking bench for alu_result_buffer (DATA_W=32, DEPTH=4).
module tb_alu_result_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_sel;
  logic [4:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_sel;
  logic [4:0]  out_flags;
  logic [2:0]  count;
  logic [4:0]  sticky_flags;
  logic        sticky_clr;
  logic [7:0]  exc_count;

  int total = 0;
  int bad   = 0;
  logic [40:0] exp_q [$];

  alu_result_buffer #(.DATA_W(32), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_sel       (in_sel),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_sel      (out_sel),
    .out_flags    (out_flags),
    .count        (count),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .exc_count    (exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and keep the reference queue in step with the handshakes.
  task automatic tick();
    bit push;
    bit pop;
    logic [40:0] entry;
    push  = !rst && in_valid && (exp_q.size() < 4);
    pop   = !rst && out_ready && (exp_q.size() != 0);
    entry = {in_result, in_sel, in_flags};
    @(posedge clk);
    #1;
    if (rst) exp_q.delete();
    else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(entry);
    end
  endtask

  task automatic check_head(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(exp_q.size() != 0));
    check({tag, "_count"}, 64'(count), 64'(exp_q.size()));
    if (exp_q.size() != 0)
      check({tag, "_head"}, 64'({out_result, out_sel, out_flags}), 64'(exp_q[0]));
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] s, input logic [4:0] f);
    in_valid  = v;
    in_result = r;
    in_sel    = s;
    in_flags  = f;
  endtask

  initial begin
    rst = 1'b1; sticky_clr = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 5'b0);
    tick(); tick();
    rst = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sticky", 64'(sticky_flags), 64'd0);
    check("rst_exc", 64'(exc_count), 64'd0);

    // Single push, held by a stalled consumer.
    drive(1'b1, 32'h0C0C0C0C, 4'h1, 5'b00000);
    #1 check("no_bypass", 64'(out_valid), 64'd0);
    tick();
    drive(1'b0, 32'h0, 4'h0, 5'b0);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_count", 64'(count), 64'd1);
    check("single_result", 64'(out_result), 64'h0C0C0C0C);
    check("single_sel", 64'(out_sel), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("single_stable", 64'({out_result, out_sel, out_flags}), 64'({32'h0C0C0C0C, 4'h1, 5'b0}));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_drained", 64'(count), 64'd0);

    // Five back-to-back pushes into a depth-4 buffer.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 4'(i), 5'b0);
      #1 check("fill_in_ready", 64'(in_ready), 64'(i < 4));
      tick();
    end
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("full_ignores_push", 64'(count), 64'd4);
    drive(1'b0, 32'h0, 4'h0, 5'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 64'(out_result), 64'h100 + 64'(i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", 64'(out_valid), 64'd0);

    // Full buffer with simultaneous push and pop, wrapping both pointers.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 4'(i + 2), 5'b0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h204 + 32'(k), 4'(k), 5'b0);
      tick();
      check_head("stream");
    end
    check("stream_count_hand", 64'(count), 64'd3);
    drive(1'b0, 32'h0, 4'h0, 5'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_head("stream_drain");
    end

    // Sticky flags and exception counter.
    drive(1'b1, 32'h300, 4'h3, 5'b00010);
    tick();
    drive(1'b1, 32'h301, 4'h3, 5'b00001);
    tick();
    drive(1'b0, 32'h0, 4'h0, 5'b0);
    check("sticky_or", 64'(sticky_flags), 64'b00011);
    check("exc_two", 64'(exc_count), 64'd2);
    sticky_clr = 1'b1;
    drive(1'b1, 32'h302, 4'h4, 5'b10000);
    tick();
    sticky_clr = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 5'b0);
    check("clr_push_sticky", 64'(sticky_flags), 64'b10000);
    check("clr_exc", 64'(exc_count), 64'd0);
    tick();
    check_head("sticky_drain");

    // 300 overflow pushes with an always-ready consumer.
    drive(1'b1, 32'h400, 4'h5, 5'b00010);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 253) check("exc_254", 64'(exc_count), 64'd254);
    end
    check("exc_saturated", 64'(exc_count), 64'd255);
    check("sat_sticky", 64'(sticky_flags), 64'b10010);
    sticky_clr = 1'b1;
    drive(1'b1, 32'h401, 4'h6, 5'b00001);
    tick();
    sticky_clr = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 5'b0);
    check("clr_qual_exc", 64'(exc_count), 64'd1);
    check("clr_qual_sticky", 64'(sticky_flags), 64'b00001);
    tick();
    check_head("sat_drain");
    out_ready = 1'b0;

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(i), 4'(i), 5'b00100);
      tick();
    end
    check("pre_rst_count", 64'(count), 64'd3);
    check("pre_rst_sticky", 64'(sticky_flags), 64'b00101);
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h5FF, 4'hF, 5'b00010);
    tick();
    rst = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 5'b0);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_sticky", 64'(sticky_flags), 64'd0);
    check("mid_rst_exc", 64'(exc_count), 64'd0);
    drive(1'b1, 32'hA5A5_0001, 4'h9, 5'b01000);
    tick();
    drive(1'b0, 32'h0, 4'h0, 5'b0);
    check("post_rst_result", 64'(out_result), 64'hA5A50001);
    check_head("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
